// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed byte-enable RAM behind a fixed-latency
// response pipe and an in-order output FIFO, with credit-gated request acceptance.
module dmem_responder #(
  parameter int AW         = 8,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  input  logic        resp_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

  logic [AW-1:0] idx;
  logic          oor;
  logic          accept;
  logic          pop;
  logic          push;
  logic [31:0]   push_data;
  logic          push_err;
  logic          unused_addr_bits;

  assign idx              = addr[AW+1:2];
  assign oor              = |addr[31:AW+2];
  assign unused_addr_bits = ^addr[1:0];

  logic [CW-1:0] cnt_q, cnt_d;

  assign addr_ok = !rst && (cnt_q < DEPTH_C);
  assign accept  = req && addr_ok;
  assign cnt_d   = cnt_q + CW'(accept) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // One RAM per byte lane so byte enables map onto independent write ports.
  logic [31:0] ram_rd;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [2**AW];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (accept && wr && !oor && wen[gi]) lane_mem[idx] <= wdata[8*gi +: 8];
        rd_q <= lane_mem[idx];
      end
      assign ram_rd[8*gi +: 8] = rd_q;
    end
  endgenerate

  logic        pipe_v_q [LATENCY];
  logic        pipe_e_q [LATENCY];
  logic        s0_rd_q;
  logic [31:0] s0_data;

  assign s0_data = s0_rd_q ? ram_rd : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe_v_q[k] <= 1'b0;
        pipe_e_q[k] <= 1'b0;
      end
      s0_rd_q <= 1'b0;
    end else begin
      pipe_v_q[0] <= accept;
      pipe_e_q[0] <= oor;
      s0_rd_q     <= !wr && !oor;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_v_q[k] <= pipe_v_q[k-1];
        pipe_e_q[k] <= pipe_e_q[k-1];
      end
    end
  end

  // Stage 0 data comes straight from the RAM read register; later stages copy it.
  generate
    if (LATENCY == 1) begin : g_pd_direct
      assign push_data = s0_data;
    end else begin : g_pd_regs
      logic [31:0] pd_q [1:LATENCY-1];
      always_ff @(posedge clk) begin
        pd_q[1] <= s0_data;
        for (int k = 2; k < LATENCY; k++) pd_q[k] <= pd_q[k-1];
      end
      assign push_data = pd_q[LATENCY-1];
    end
  endgenerate

  assign push     = pipe_v_q[LATENCY-1];
  assign push_err = pipe_e_q[LATENCY-1];

  logic [31:0]   fifo_d [FIFO_DEPTH];
  logic          fifo_e [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d, keep;
  logic          data_ok_q, data_ok_d, err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign pop = data_ok_q && resp_ready;

  // Head registers take the next head: an older stored entry if one remains,
  // otherwise the entry being pushed this cycle.
  always_comb begin
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    fcnt_d    = fcnt_q + CW'(push) - CW'(pop);
    keep      = fcnt_q - CW'(pop);
    data_ok_d = (keep != '0) || push;
    rdata_d   = 32'd0;
    err_d     = 1'b0;
    if (keep != '0) begin
      rdata_d = fifo_d[rd_ptr_d];
      err_d   = fifo_e[rd_ptr_d];
    end else if (push) begin
      rdata_d = push_data;
      err_d   = push_err;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_d[wr_ptr_q] <= push_data;
      fifo_e[wr_ptr_q] <= push_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      fcnt_q    <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      fcnt_q    <= fcnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a queue-based
// model of accepted requests with their response-ready times.
module tb_dmem_responder;

  localparam int AW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        resp_ready = 1'b1;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;

  dmem_responder #(.AW(AW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .wen(wen), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .err(err), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted request sits in q until popped; its response is
  // visible once LAT edges have passed since acceptance.
  typedef struct {
    logic [31:0] d;
    logic        e;
    int          ready;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mm [2**AW];
  int          ec = 0;

  initial begin
    forever begin
      @(posedge clk);
      begin
        bit          exp_ok, acc;
        bit          a_oor;
        int          a_idx;
        resp_t       r;
        exp_ok = (q.size() > 0) && (q[0].ready <= ec);
        ec++;
        if (rst) begin
          q.delete();
        end else begin
          acc = req && (q.size() < DEPTH);
          if (exp_ok && resp_ready) void'(q.pop_front());
          if (acc) begin
            a_oor = (addr >> (AW + 2)) != 0;
            a_idx = int'((addr >> 2) % (2**AW));
            r.e     = a_oor;
            r.d     = (!wr && !a_oor) ? mm[a_idx] : 32'd0;
            r.ready = ec + LAT;
            q.push_back(r);
            if (wr && !a_oor)
              for (int b = 0; b < 4; b++)
                if (wen[b]) mm[a_idx][8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Compare process: every cycle once checking is enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit exp_aok, exp_dok;
        exp_aok = !rst && (q.size() < DEPTH);
        exp_dok = (q.size() > 0) && (q[0].ready <= ec);
        chk("addr_ok", {31'd0, addr_ok}, {31'd0, exp_aok});
        chk("data_ok", {31'd0, data_ok}, {31'd0, exp_dok});
        if (exp_dok && data_ok) begin
          chk("rdata", rdata, q[0].d);
          chk("err", {31'd0, err}, {31'd0, q[0].e});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic w, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] d);
    bit got;
    got = 1'b0;
    req = 1'b1; wr = w; wen = be; addr = a; wdata = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (addr_ok) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic expect_resp(input string name, input logic [31:0] exp_d, input logic exp_e);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (data_ok) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({name, "_rdata"}, rdata, exp_d);
      chk({name, "_err"}, {31'd0, err}, {31'd0, exp_e});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc_cnt;
    int i;
    bit adv;

    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_addr_ok", {31'd0, addr_ok}, 32'd1);
    @(posedge clk); #1;

    // Fill every word so later reads have a defined model value.
    i = 0;
    while (i < 2**AW) begin
      req = 1'b1; wr = 1'b1; wen = 4'hF; addr = 32'(i) << 2; wdata = $urandom;
      @(negedge clk); adv = addr_ok;
      @(posedge clk); #1;
      if (adv) i++;
    end
    req = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Basic write/read and byte lanes
    send(1'b1, 4'hF, 32'h10, 32'hDEADBEEF); expect_resp("wr1", 32'd0, 1'b0);
    send(1'b0, 4'h0, 32'h10, 32'd0);        expect_resp("rd1", 32'hDEADBEEF, 1'b0);
    send(1'b1, 4'b0010, 32'h10, 32'h0000AB00); expect_resp("wr_lane", 32'd0, 1'b0);
    send(1'b0, 4'h0, 32'h10, 32'd0);        expect_resp("rd_lane", 32'hDEADABEF, 1'b0);
    send(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF); expect_resp("wr_wen0", 32'd0, 1'b0);
    send(1'b0, 4'h0, 32'h10, 32'd0);        expect_resp("rd_wen0", 32'hDEADABEF, 1'b0);

    // Back-pressure: only DEPTH requests fit
    resp_ready = 1'b0;
    req = 1'b1; wr = 1'b0; addr = 32'h10; acc_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (addr_ok) acc_cnt++;
      @(posedge clk); #1;
    end
    req = 1'b0;
    chk("bp_accepts", 32'(acc_cnt), 32'(DEPTH));
    resp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Out-of-range accesses alias nothing
    send(1'b1, 4'hF, 32'h0, 32'h12345678);  expect_resp("wr0", 32'd0, 1'b0);
    send(1'b0, 4'h0, 32'h1 << (AW + 2), 32'd0); expect_resp("rd_oor", 32'd0, 1'b1);
    send(1'b1, 4'hF, 32'h1 << (AW + 2), 32'hFFFFFFFF); expect_resp("wr_oor", 32'd0, 1'b1);
    send(1'b0, 4'h0, 32'h0, 32'd0);         expect_resp("rd0_after_oor", 32'h12345678, 1'b0);

    // Back-to-back write then read of the same word
    req = 1'b1; wr = 1'b1; wen = 4'hF; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge clk); #1 wr = 1'b0;
    @(posedge clk); #1 req = 1'b0;
    expect_resp("b2b_wr", 32'd0, 1'b0);
    expect_resp("b2b_rd", 32'hCAFEF00D, 1'b0);

    // Reset with requests in flight
    send(1'b1, 4'hF, 32'h30, 32'h0BADCAFE); expect_resp("wr30", 32'd0, 1'b0);
    resp_ready = 1'b0;
    req = 1'b1; wr = 1'b0; addr = 32'h30;
    repeat (3) begin @(posedge clk); #1; end
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_addr_ok", {31'd0, addr_ok}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    @(posedge clk); #1 resp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(1'b0, 4'h0, 32'h30, 32'd0); expect_resp("rd30_after_rst", 32'h0BADCAFE, 1'b0);

    // Random traffic with random back-pressure and occasional resets
    repeat (3000) begin
      req        = ($urandom % 3) != 0;
      wr         = $urandom % 2;
      wen        = 4'($urandom);
      wdata      = $urandom;
      addr       = (($urandom % 10) == 0) ? $urandom : (32'($urandom) & 32'h3FF);
      resp_ready = ($urandom % 4) != 0;
      rst        = ($urandom % 500) == 0;
      @(posedge clk); #1;
    end
    req = 1'b0; rst = 1'b0; resp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
